// File: rtl/serial_compare_n_if.sv
// Serial operand link for serial_compare_n: bit pairs in, status and flags out.
interface serial_compare_n_if;
  logic start;
  logic bit_valid;
  logic x_bit;
  logic y_bit;
  logic busy;
  logic done;
  logic XGY;
  logic XSY;
  logic XEY;

  modport master (
    output start, bit_valid, x_bit, y_bit,
    input  busy, done, XGY, XSY, XEY
  );

  modport slave (
    input  start, bit_valid, x_bit, y_bit,
    output busy, done, XGY, XSY, XEY
  );
endinterface

// File: rtl/serial_compare_n.sv
// Bit-serial magnitude comparator, MSB first by default.
// Define SERIAL_CMP_LSB_FIRST_EN for LSB-first operand order.
module serial_compare_n #(
  parameter int WIDTH = 8,
  parameter int CW    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_compare_n_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    V_EQ,
    V_GT,
    V_LT
  } verd_t;

  state_t        state_q, state_d;
  verd_t         verd_q, verd_d;
  verd_t         verd_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    flg_q, flg_d;
  logic          last;
  logic          diff;

  assign diff = bus.x_bit ^ bus.y_bit;
  assign last = (cnt_q == CW'(1));

  // Verdict after consuming the current bit pair
  always_comb begin
    verd_nx = verd_q;
`ifdef SERIAL_CMP_LSB_FIRST_EN
    if (diff)
      verd_nx = bus.x_bit ? V_GT : V_LT;
`else
    if (diff && verd_q == V_EQ)
      verd_nx = bus.x_bit ? V_GT : V_LT;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    verd_d  = verd_q;
    flg_d   = flg_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          cnt_d   = CW'(WIDTH);
          verd_d  = V_EQ;
        end
      end
      S_RUN: begin
        if (bus.bit_valid) begin
          cnt_d  = cnt_q - CW'(1);
          verd_d = verd_nx;
          if (last) begin
            state_d = S_DONE;
            unique case (1'b1)
              (verd_nx == V_GT): flg_d = 3'b100;
              (verd_nx == V_LT): flg_d = 3'b010;
              default:           flg_d = 3'b001;
            endcase
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      verd_q  <= V_EQ;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      verd_q  <= verd_d;
      flg_q   <= flg_d;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.XGY  = flg_q[2];
  assign bus.XSY  = flg_q[1];
  assign bus.XEY  = flg_q[0];

endmodule

// File: doc/serial_compare_n.md
Name: serial_compare_n

Overview:
- Bit-serial magnitude comparator: the sequential, serial-input counterpart of the team's parallel n-bit comparator.
- Receives operands X and Y one bit pair per accepted cycle, MSB first by default.
- Produces the same three flags: XGY, XSY, XEY.
- Sits at the receiving end of a serial link where parallel operands are not available; reports results with a done pulse.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- CW, 6, bit-counter width; must satisfy 2**CW > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a new comparison; sampled only in IDLE
- bit_valid  input  1  x_bit/y_bit hold a valid bit pair this cycle
- x_bit  input  1  current serial bit of X
- y_bit  input  1  current serial bit of Y
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse: result flags updated
- XGY  output  1  X greater than Y (registered)
- XSY  output  1  X smaller than Y (registered)
- XEY  output  1  X equal to Y (registered)

Behaviour:
- Reset: the clock and reset are fixed as one clock, clk, with asynchronous active-low reset, rst_n. Asserting rst_n=0 immediately forces:
  - state=IDLE, counter=0, internal verdict=EQ;
  - busy=0, done=0, XGY=0, XSY=0, XEY=0.
- Reset mid-RUN aborts the comparison; no done pulse is produced.
- States:
  - IDLE: start=1 -> RUN; counter loads WIDTH, verdict=EQ, busy=1 from the next cycle. bit_valid is ignored in IDLE.
  - RUN: each edge with bit_valid=1 consumes one bit pair and decrements the counter.
    - Verdict update, MSB-first mode: only while verdict==EQ. x_bit=1,y_bit=0 -> GT; x_bit=0,y_bit=1 -> LT; equal bits -> stays EQ.
    - Once GT or LT is set, later bits are consumed but do not change it.
    - bit_valid=0 cycles: no consumption, no counter change; gaps of any length are legal.
  - On the edge consuming bit number WIDTH:
    - state -> DONE;
    - XGY/XSY/XEY load the final verdict, including that last bit's effect; exactly one flag is high;
    - done=1.
  - DONE: lasts exactly one cycle -> IDLE; done returns to 0, busy=0.
- Latency: done is asserted in the cycle after the edge that samples the last bit. Minimum, with bit_valid held high: start edge + WIDTH edges.
- Flags hold their last result through IDLE and the next RUN. They change only at the DONE load or on reset.
- Boundary conditions:
  - start while busy, or in the DONE cycle, is ignored.
  - start and bit_valid high together in IDLE: start is accepted; that cycle's bits are not consumed.
  - Counter never wraps; it reaches 0 only at the DONE transition.

Optional Feature:
- Macro: SERIAL_CMP_LSB_FIRST_EN.
- Defined: operands arrive LSB first. Every differing bit pair overwrites the verdict (x=1,y=0 -> GT; x=0,y=1 -> LT); equal pairs leave it unchanged. The verdict is therefore set by the most significant differing bit, which arrives last.
- Not defined: MSB-first first-difference-wins rule as above.
- Handshake, latency and reset are identical in both builds.

Test Plan (WIDTH=8):
- Equal operands: start, then X=0xA5, Y=0xA5 over 8 consecutive valid cycles -> done pulse 1 cycle after the 8th bit; XEY=1, XGY=0, XSY=0; busy low after the pulse.
- Early decision: MSB-first, X=0x80, Y=0x7F -> verdict fixed at bit 7; XGY=1, XSY=0, XEY=0 only after the 8th bit (no early done).
- Gapped stream: X=0x3C, Y=0x3D with bit_valid low for 3 cycles between bits 2 and 3 -> XSY=1; done exactly 1 cycle after the 8th valid bit.
- Start ignored: second start mid-RUN and in the DONE cycle, with X=0x10, Y=0x01 -> single done pulse, XGY=1. The next start in IDLE begins a fresh compare, and flags hold 0x10>0x01 until it completes.
- Reset mid-operation: rst_n low after 4 of 8 bits -> busy, done and all flags 0 immediately; no done pulse. A following full compare of X=0xFF, Y=0x00 gives XGY=1.
- LSB-first build (SERIAL_CMP_LSB_FIRST_EN): X=0x01, Y=0x02 sent LSB first -> XSY=1. X=0x81, Y=0x02 -> XGY=1 (bit 7 overrides).
